addertree_accum: RTL and testbench

Pipelined final stage of the convolution adder tree. It receives the two fully compressed rows produced by the last carry-save compression stage, adds them with a carry-propagate adder, and accumulates the result across input channels into a signed accumulator seeded with a bias. When a group ends it applies optional ReLU and signed saturation, then presents one output word per group over a valid/ready handshake.

---
 rtl/addertree_accum.sv | 141 ++++++++++++++
 tb/tb_addertree_accum.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/addertree_accum.sv
// Final adder-tree stage: carry-propagate add of the two compressed rows, bias-seeded
// per-group accumulation, then ReLU/saturation and a valid/ready output word per group.
module addertree_accum #(
    parameter int IN_W  = 20,
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    input  logic             in_last,
    input  logic [ACC_W-1:0] bias,
    input  logic             cfg_relu,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             acc_ovf
);

    localparam logic signed [ACC_W-1:0] OUT_MAX_C = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN_C = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic add_ovf_fn(input logic [ACC_W-1:0] x,
                                        input logic [ACC_W-1:0] y,
                                        input logic [ACC_W-1:0] r);
        return (x[ACC_W-1] == y[ACC_W-1]) && (r[ACC_W-1] != x[ACC_W-1]);
    endfunction

    // Returns {clipped, data}.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W-1:0] v);
        logic [OUT_W:0] res;
        if (v > OUT_MAX_C) begin
            res = {1'b1, OUT_MAX_C[OUT_W-1:0]};
        end else if (v < OUT_MIN_C) begin
            res = {1'b1, OUT_MIN_C[OUT_W-1:0]};
        end else begin
            res = {1'b0, v[OUT_W-1:0]};
        end
        return res;
    endfunction

    logic                    adv_s;
    logic                    a_v_r;
    logic [IN_W:0]           sum_a_r;
    logic                    a_last_r;
    logic signed [ACC_W-1:0] acc_r;
    logic                    first_r;
    logic                    b_v_r;
    logic                    acc_ovf_r;
    logic                    out_valid_r;
    logic [OUT_W-1:0]        out_data_r;
    logic                    out_sat_r;

    logic [ACC_W-1:0]        base_s;
    logic [ACC_W-1:0]        addend_s;
    logic [ACC_W-1:0]        acc_next_s;
    logic                    ovf_s;
    logic signed [ACC_W-1:0] relu_s;
    logic [OUT_W:0]          sat_s;

    assign adv_s     = !out_valid_r || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sat   = out_sat_r;
    assign acc_ovf   = acc_ovf_r;

    // Accumulate datapath and output shaping from current register state.
    always_comb begin
        base_s   = acc_r;
        addend_s = {{(ACC_W-IN_W-1){1'b0}}, sum_a_r};
        if (first_r) begin
            base_s = bias;
        end else begin
            base_s = acc_r;
        end
        acc_next_s = base_s + addend_s;
        ovf_s      = add_ovf_fn(base_s, addend_s, acc_next_s);
        if (cfg_relu && acc_r[ACC_W-1]) begin
            relu_s = {ACC_W{1'b0}};
        end else begin
            relu_s = acc_r;
        end
        sat_s = sat_fn(relu_s);
    end

    // Stage A: carry-propagate sum of the two compressed rows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_v_r    <= 1'b0;
            sum_a_r  <= {(IN_W+1){1'b0}};
            a_last_r <= 1'b0;
        end else if (adv_s) begin
            a_v_r <= in_valid;
            if (in_valid) begin
                sum_a_r  <= {1'b0, in_a} + {1'b0, in_b};
                a_last_r <= in_last;
            end
        end
    end

    // Stage B: bias-seeded accumulation; bubbles leave acc and first untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_r     <= {ACC_W{1'b0}};
            first_r   <= 1'b1;
            b_v_r     <= 1'b0;
            acc_ovf_r <= 1'b0;
        end else if (adv_s) begin
            if (a_v_r) begin
                acc_r     <= acc_next_s;
                first_r   <= a_last_r;
                b_v_r     <= a_last_r;
                acc_ovf_r <= acc_ovf_r | ovf_s;
            end else begin
                b_v_r <= 1'b0;
            end
        end
    end

    // Stage C: capture finished group (old acc value) into the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_sat_r   <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= b_v_r;
            if (b_v_r) begin
                out_data_r <= sat_s[OUT_W-1:0];
                out_sat_r  <= sat_s[OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_addertree_accum.sv
// Directed bench for addertree_accum: one task per scenario with inline checks.
module tb_addertree_accum;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_a;
    logic [19:0] in_b;
    logic        in_last;
    logic [31:0] bias;
    logic        cfg_relu;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        acc_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    addertree_accum #(.IN_W(20), .ACC_W(32), .OUT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .bias(bias), .cfg_relu(cfg_relu),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .acc_ovf(acc_ovf)
    );

    task automatic send_beat(input logic [19:0] a, input logic [19:0] b, input logic last);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; in_a = 20'd0; in_b = 20'd0; in_last = 1'b0;
        bias = 32'd0; cfg_relu = 1'b0; out_ready = 1'b0;
        idle(2);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 16'd0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat: got %b want 0", out_sat); else n_pass++;
        n_checks++; if (acc_ovf !== 1'b0) $display("FAIL reset_acc_ovf: got %b want 0", acc_ovf); else n_pass++;
        out_ready = 1'b1;
        reset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_single;
        bias = 32'd0; cfg_relu = 1'b0; out_ready = 1'b1;
        send_beat(20'd100, 20'd23, 1'b1);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_lat_k: got %b want 0", out_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_lat_k1: got %b want 0", out_valid); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_lat_k2: got %b want 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 16'd123) $display("FAIL single_data: got %0d want 123", $signed(out_data)); else n_pass++;
        n_checks++; if (out_sat !== 1'b0) $display("FAIL single_sat: got %b want 0", out_sat); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drop: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_three(input logic relu, input logic [15:0] exp_data);
        bit ok;
        bias = -32'sd500; cfg_relu = relu; out_ready = 1'b1;
        send_beat(20'd100, 20'd0, 1'b0);
        send_beat(20'd150, 20'd50, 1'b0);
        send_beat(20'd75, 20'd75, 1'b1);
        wait_out(ok);
        n_checks++; if (!ok) $display("FAIL three_timeout relu=%b: got no out_valid want out_valid", relu); else n_pass++;
        n_checks++; if (out_data !== exp_data) $display("FAIL three_data relu=%b: got %0d want %0d", relu, $signed(out_data), $signed(exp_data)); else n_pass++;
        n_checks++; if (out_sat !== 1'b0) $display("FAIL three_sat relu=%b: got %b want 0", relu, out_sat); else n_pass++;
        idle(2);
        cfg_relu = 1'b0;
    endtask

    task automatic test_saturation(input logic [31:0] b_seed, input logic [15:0] exp_data);
        bit ok;
        bias = b_seed; cfg_relu = 1'b0; out_ready = 1'b1;
        send_beat(20'hFFFFF, 20'hFFFFF, 1'b0);
        send_beat(20'hFFFFF, 20'hFFFFF, 1'b1);
        wait_out(ok);
        n_checks++; if (!ok) $display("FAIL sat_timeout: got no out_valid want out_valid"); else n_pass++;
        n_checks++; if (out_data !== exp_data) $display("FAIL sat_data: got %0d want %0d", $signed(out_data), $signed(exp_data)); else n_pass++;
        n_checks++; if (out_sat !== 1'b1) $display("FAIL sat_flag: got %b want 1", out_sat); else n_pass++;
        idle(2);
    endtask

    task automatic test_back_to_back;
        bias = 32'd0; cfg_relu = 1'b0; out_ready = 1'b1;
        send_beat(20'd10, 20'd0, 1'b1);
        send_beat(20'd15, 20'd5, 1'b1);
        send_beat(20'd30, 20'd0, 1'b1);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'd10) $display("FAIL b2b_0: got v=%b d=%0d want v=1 d=10", out_valid, out_data); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'd20) $display("FAIL b2b_1: got v=%b d=%0d want v=1 d=20", out_valid, out_data); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'd30) $display("FAIL b2b_2: got v=%b d=%0d want v=1 d=30", out_valid, out_data); else n_pass++;
        idle(2);
    endtask

    task automatic test_backpressure;
        int sent;
        int hold;
        bit seen;
        bit acc_now;
        logic [15:0] got[$];
        sent = 0; hold = 0; seen = 1'b0;
        bias = 32'd0; cfg_relu = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_a = 20'd1; in_b = 20'd0; in_last = 1'b1;
        for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
            if (out_valid && !seen) begin
                seen = 1'b1;
                hold = 4;
            end
            if (hold > 0) begin
                out_ready = 1'b0;
                #1;
                n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
                n_checks++; if (out_data !== 16'd1) $display("FAIL bp_hold_data: got %0d want 1", out_data); else n_pass++;
                hold--;
            end else begin
                out_ready = 1'b1;
                #1;
            end
            acc_now = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_data);
            @(posedge clk); #1;
            if (acc_now) sent++;
            if (sent < 6) begin
                in_valid = 1'b1;
                in_a = 20'(sent + 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got.size() != 6) $display("FAIL bp_count: got %0d want 6", got.size()); else n_pass++;
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== 16'(i + 1)) $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], i + 1); else n_pass++;
        end
        idle(2);
    endtask

    task automatic test_reset_mid;
        bit ok;
        bias = 32'd0; cfg_relu = 1'b0; out_ready = 1'b1;
        send_beat(20'd50, 20'd0, 1'b0);
        send_beat(20'd25, 20'd25, 1'b0);
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        send_beat(20'd7, 20'd0, 1'b1);
        wait_out(ok);
        n_checks++; if (!ok) $display("FAIL rstmid_timeout: got no out_valid want out_valid"); else n_pass++;
        n_checks++; if (out_data !== 16'd7) $display("FAIL rstmid_data: got %0d want 7", $signed(out_data)); else n_pass++;
        n_checks++; if (acc_ovf !== 1'b0) $display("FAIL rstmid_ovf: got %b want 0", acc_ovf); else n_pass++;
        idle(2);
    endtask

    task automatic test_overflow;
        bit ok;
        bias = 32'h7FFF_FFFF; cfg_relu = 1'b0; out_ready = 1'b1;
        send_beat(20'd1, 20'd0, 1'b1);
        wait_out(ok);
        n_checks++; if (!ok) $display("FAIL ovf_timeout: got no out_valid want out_valid"); else n_pass++;
        n_checks++; if (acc_ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", acc_ovf); else n_pass++;
        n_checks++; if (out_data !== 16'h8000) $display("FAIL ovf_data: got %0d want -32768", $signed(out_data)); else n_pass++;
        n_checks++; if (out_sat !== 1'b1) $display("FAIL ovf_sat: got %b want 1", out_sat); else n_pass++;
        idle(2);
        bias = 32'd0;
        send_beat(20'd5, 20'd0, 1'b1);
        wait_out(ok);
        n_checks++; if (!ok || out_data !== 16'd5) $display("FAIL ovf_next_data: got %0d want 5", $signed(out_data)); else n_pass++;
        n_checks++; if (acc_ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", acc_ovf); else n_pass++;
        idle(2);
        #2 reset_n = 1'b0;
        #2;
        n_checks++; if (acc_ovf !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", acc_ovf); else n_pass++;
        reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_three(1'b0, 16'hFFCE);
        test_three(1'b1, 16'd0);
        test_saturation(32'd0, 16'h7FFF);
        test_saturation(-32'sd8000000, 16'h8000);
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
